// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: op codes, FSM states, decode funct values and op-class helpers.
// Optional feature macro: MDU_MADD_EN (enables madd/maddu/msub/msubu ops 6-9).
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MDU_MULT  = 4'd0,
        MDU_MULTU = 4'd1,
        MDU_DIV   = 4'd2,
        MDU_DIVU  = 4'd3,
        MDU_MTHI  = 4'd4,
        MDU_MTLO  = 4'd5,
        MDU_MADD  = 4'd6,
        MDU_MADDU = 4'd7,
        MDU_MSUB  = 4'd8,
        MDU_MSUBU = 4'd9
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // R-type funct fields used by the D-stage decoder to build d_is_mdu
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    function automatic logic is_mdu_funct(input logic [5:0] funct);
        return (funct == FUNCT_MFHI)  || (funct == FUNCT_MTHI)  ||
               (funct == FUNCT_MFLO)  || (funct == FUNCT_MTLO)  ||
               (funct == FUNCT_MULT)  || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)   || (funct == FUNCT_DIVU);
    endfunction

    function automatic logic is_mult_class(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_MADD) || (op == MDU_MADDU) ||
               (op == MDU_MSUB) || (op == MDU_MSUBU);
`else
        return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
    endfunction

    function automatic logic is_div_class(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Combinational MDU datapath: product, quotient/remainder, divide-by-zero hold, accumulate.
// Optional feature macro: MDU_MADD_EN (adds the 64-bit accumulate/subtract paths).
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        prod_s     = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        prod_u     = {32'd0, rs_val} * {32'd0, rt_val};
        div_signed = (op == MDU_DIV);

        // Signed divide on magnitudes; 0x80000000 / -1 naturally yields 0x80000000 rem 0
        rs_mag = (div_signed && rs_val[31]) ? -rs_val : rs_val;
        rt_mag = (div_signed && rt_val[31]) ? -rt_val : rt_val;
        q_mag  = (rt_val == '0) ? '0 : rs_mag / rt_mag;
        r_mag  = (rt_val == '0) ? '0 : rs_mag % rt_mag;
        quot   = (div_signed && (rs_val[31] ^ rt_val[31])) ? -q_mag : q_mag;
        rem    = (div_signed && rs_val[31]) ? -r_mag : r_mag;

        result = {hi, lo};
        case (op)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV,
            MDU_DIVU: begin
                if (rt_val != '0) begin
                    result = {rem, quot};
                end
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  result = {hi, lo} + prod_s;
            MDU_MADDU: result = {hi, lo} + prod_u;
            MDU_MSUB:  result = {hi, lo} - prod_s;
            MDU_MSUBU: result = {hi, lo} - prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: owns HI/LO, counts mult/div latency, and drives the D-stage stall request.
// Optional feature macro: MDU_MADD_EN (madd-class ops 6-9 run as mult-class).
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_mdu,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] arith_res;
    logic        start_mult;
    logic        start_div;

    mdu_arith u_arith (
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (arith_res)
    );

    always_comb begin
        start_mult = start && is_mult_class(op);
        start_div  = start && is_div_class(op);

        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start_mult) begin
                    pend_d  = arith_res;
                    cnt_d   = MULT_CYCLES[3:0];
                    state_d = ST_BUSY;
                end else if (start_div) begin
                    // Divide by zero: arith returns the current {HI,LO}, so commit is a no-op
                    pend_d  = arith_res;
                    cnt_d   = DIV_CYCLES[3:0];
                    state_d = ST_BUSY;
                end else if (start && (op == MDU_MTHI)) begin
                    hi_d = rs_val;
                end else if (start && (op == MDU_MTLO)) begin
                    lo_d = rs_val;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd1) begin
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy      = (state_q == ST_BUSY);
        stall_req = d_is_mdu && (busy || start_mult || start_div);
        hi_out    = hi_q;
        lo_out    = lo_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // The hazard unit must never issue a new MDU write op while one is in flight
    a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset)
        !(start && (state_q == ST_BUSY)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed cases plus randomized ops against a behavioural model.
// Build with MDU_MADD_EN defined to also exercise the accumulate ops.
module tb_mdu_ctrl;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_mdu;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .d_is_mdu  (d_is_mdu),
        .busy      (busy),
        .stall_req (stall_req),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: returns 1 for multi-cycle ops, with the {HI,LO} they commit and latency
    function automatic bit ref_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] h, input logic [31:0] l,
                                  output logic [31:0] nh, output logic [31:0] nl,
                                  output int unsigned lat);
        longint          sp;
        longint unsigned up;
        longint unsigned acc;
        int              sq;
        int              sr;
        sp  = longint'($signed(a)) * longint'($signed(b));
        up  = longint'({32'd0, a}) * longint'({32'd0, b});
        acc = {h, l};
        nh  = h;
        nl  = l;
        lat = 0;
        case (o)
            4'd0: begin {nh, nl} = sp; lat = MC; return 1; end
            4'd1: begin {nh, nl} = up; lat = MC; return 1; end
            4'd2: begin
                lat = DC;
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        nl = 32'h8000_0000;
                        nh = 32'd0;
                    end else begin
                        sq = $signed(a) / $signed(b);
                        sr = $signed(a) % $signed(b);
                        nl = sq;
                        nh = sr;
                    end
                end
                return 1;
            end
            4'd3: begin
                lat = DC;
                if (b != 0) begin
                    nl = a / b;
                    nh = a % b;
                end
                return 1;
            end
            4'd4: nh = a;
            4'd5: nl = a;
`ifdef MDU_MADD_EN
            4'd6: begin {nh, nl} = acc + longint'(sp); lat = MC; return 1; end
            4'd7: begin {nh, nl} = acc + up;           lat = MC; return 1; end
            4'd8: begin {nh, nl} = acc - longint'(sp); lat = MC; return 1; end
            4'd9: begin {nh, nl} = acc - up;           lat = MC; return 1; end
`endif
            default: ;
        endcase
        return 0;
    endfunction

    task automatic do_op(input string name, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic d);
        logic [31:0] nh, nl;
        int unsigned lat;
        bit          md;
        @(posedge clk);
        #1;
        start    = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        d_is_mdu = d;
        md = ref_op(o, a, b, m_hi, m_lo, nh, nl, lat);
        if (md) sb.push_back('{name, nh, nl, lat});
        @(negedge clk);
        chk({name, "_stall_start"}, {63'd0, stall_req}, {63'd0, d & md});
        chk({name, "_busy_start"}, {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = 4'($urandom_range(0, 15));
        rs_val = $urandom;
        rt_val = $urandom;
        if (md) begin
            for (int unsigned i = 0; i <= lat; i++) begin
                @(negedge clk);
                chk({name, "_busy"}, {63'd0, busy}, {63'd0, i < lat});
                chk({name, "_stall"}, {63'd0, stall_req}, {63'd0, d && (i < lat)});
                if (i < lat) chk({name, "_hilo_hold"}, {hi_out, lo_out}, {m_hi, m_lo});
            end
        end else begin
            @(negedge clk);
            chk({name, "_busy"}, {63'd0, busy}, 64'd0);
            chk({name, "_hilo"}, {hi_out, lo_out}, {nh, nl});
        end
        m_hi     = nh;
        m_lo     = nl;
        d_is_mdu = 1'b0;
    endtask

    // Monitor: every non-reset busy fall commits the oldest expected result
    logic        prev_busy = 1'b0;
    logic        prev_rst  = 1'b1;
    int unsigned bcnt      = 0;
    always @(negedge clk) begin
        if (busy) begin
            bcnt++;
        end else if (prev_busy && !prev_rst) begin
            if (sb.size() == 0) begin
                chk("unexpected_completion", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, {hi_out, lo_out}, {e.hi, e.lo});
                chk({e.name, "_latency"}, 64'(bcnt), 64'(e.lat));
            end
        end
        if (!busy) bcnt = 0;
        prev_busy = busy;
        prev_rst  = reset;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rop;
        reset    = 1'b1;
        start    = 1'b0;
        op       = '0;
        rs_val   = '0;
        rt_val   = '0;
        d_is_mdu = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_stall", {63'd0, stall_req}, 64'd0);
        chk("reset_hilo", {hi_out, lo_out}, 64'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        d_is_mdu = 1'b0;

        do_op("mult_neg3x7", 4'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        chk("mult_neg3x7_val", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op("divu_100_7", 4'd3, 32'd100, 32'd7, 1'b0);
        do_op("div_neg7_2", 4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op("mthi_11", 4'd4, 32'h11, 32'h0, 1'b0);
        do_op("mtlo_22", 4'd5, 32'h22, 32'h0, 1'b0);
        do_op("div_by_zero", 4'd2, 32'd1234, 32'd0, 1'b0);
        do_op("mult_stall", 4'd0, 32'd9, 32'd9, 1'b1);
        do_op("div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

        // Reset on busy cycle 3 of a DIV: pending result must be discarded
        @(posedge clk);
        #1;
        start  = 1'b1;
        op     = 4'd2;
        rs_val = 32'd1000;
        rt_val = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy_before", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_hilo", {hi_out, lo_out}, 64'd0);
        repeat (12) @(negedge clk);
        chk("rst_mid_no_commit", {hi_out, lo_out}, 64'd0);
        chk("rst_mid_busy_late", {63'd0, busy}, 64'd0);

`ifdef MDU_MADD_EN
        do_op("mthi_0", 4'd4, 32'h0, 32'h0, 1'b0);
        do_op("mtlo_ff", 4'd5, 32'hFFFF_FFFF, 32'h0, 1'b0);
        do_op("maddu_1x1", 4'd7, 32'd1, 32'd1, 1'b0);
        chk("maddu_1x1_val", {m_hi, m_lo}, 64'h0000_0001_0000_0000);
`else
        do_op("mthi_5", 4'd4, 32'h5, 32'h0, 1'b0);
        do_op("undef_op6", 4'd6, 32'd3, 32'd4, 1'b1);
        do_op("undef_op12", 4'd12, 32'd3, 32'd4, 1'b1);
`endif

        for (int i = 0; i < 40; i++) begin
`ifdef MDU_MADD_EN
            rop = 4'($urandom_range(0, 9));
`else
            rop = 4'($urandom_range(0, 5));
`endif
            do_op("rand", rop,
                  ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'h0 :
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
                  1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
